fft_output_unloader: RTL and testbench

Streams the 64-point DIF FFT result out of the two 32-word dual-port banks in natural frequency order over a valid/ready interface. Starts on the rising edge of the FFT controller's `output_start` and drives the bank read ports during unload. Undoes the in-place bit-reversed layout and the parity bank interleave, and absorbs downstream backpressure with a 2-entry buffer.

---
 rtl/fft_pkg.sv | 28 ++
 rtl/fft_skid_fifo.sv | 48 ++++
 rtl/fft_output_unloader.sv | 148 ++++++++++++++
 tb/tb_fft_output_unloader.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants and memory-map helpers, used by both the write side
// and the output unloader so they agree on the bank/address layout.
package fft_pkg;

    localparam int N       = 64;
    localparam int LOGN    = 6;
    localparam int BANK_AW = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } unload_state_e;

    // Mirror the 6 index bits: DIF output bin n lives at location bitrev6(n).
    function automatic logic [LOGN-1:0] bitrev6(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[LOGN-1-i] = v[i];
        end
        return r;
    endfunction

    // Bank select: XOR of all index bits (invariant under bit reversal).
    function automatic logic parity6(input logic [LOGN-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/fft_skid_fifo.sv
// Two-entry FIFO that absorbs downstream backpressure on the unload stream.
module fft_skid_fifo #(
    parameter int W = 39
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    // Storage and pointers; entries cleared on reset so the head reads 0.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fft_output_unloader.sv
// Streams the 64 FFT bins out of the two parity-interleaved banks in natural
// order, undoing the bit-reversed DIF layout, over a valid/ready interface.
module fft_output_unloader
    import fft_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               output_start,
    output logic               re_b0,
    output logic               re_b1,
    output logic [BANK_AW-1:0] raddr_b0,
    output logic [BANK_AW-1:0] raddr_b1,
    input  logic [DW-1:0]      rdata_b0,
    input  logic [DW-1:0]      rdata_b1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [LOGN-1:0]    out_index,
    output logic               out_last,
    output logic               busy,
    output logic               overrun
);

    localparam int EW = DW + LOGN + 1;

    unload_state_e      state_q, state_d;
    logic               start_prev_q;
    logic               armed_q;
    logic [LOGN:0]      rd_n_q, rd_n_d;
    logic               overrun_q, overrun_d;
    logic               inflight_q;
    logic               bank_q;
    logic [LOGN-1:0]    n_q;

    logic               start_edge;
    logic               pop;
    logic               final_hs;
    logic               rd_issue;
    logic               rd_bank;
    logic [BANK_AW-1:0] rd_addr;
    logic [1:0]         fifo_count;
    logic [EW-1:0]      fifo_wdata;
    logic [EW-1:0]      fifo_head;

    // armed_q blocks a level that was already high when reset released from
    // looking like a fresh request; a low must be seen first.
    assign start_edge = output_start & ~start_prev_q & armed_q;
    assign out_valid  = (fifo_count != 2'd0);
    assign pop        = out_valid & out_ready;
    assign {out_data, out_index, out_last} = fifo_head;
    assign final_hs   = pop & out_last;
    assign busy       = (state_q == ST_DRAIN);
    assign overrun    = overrun_q;

    // Read issue and bank port drive: only the parity bank of rd_n is enabled,
    // and only while FIFO plus in-flight word leave room after this cycle's pop.
    always_comb begin
        rd_issue = 1'b0;
        re_b0    = 1'b0;
        re_b1    = 1'b0;
        raddr_b0 = '0;
        raddr_b1 = '0;
        rd_bank  = parity6(rd_n_q[LOGN-1:0]);
        rd_addr  = BANK_AW'(bitrev6(rd_n_q[LOGN-1:0]) >> 1);
        if (state_q == ST_DRAIN && !rd_n_q[LOGN] &&
            ({1'b0, fifo_count} + {2'b00, inflight_q} < 3'd2 + {2'b00, pop})) begin
            rd_issue = 1'b1;
        end
        if (rd_issue) begin
            if (rd_bank) begin
                re_b1    = 1'b1;
                raddr_b1 = rd_addr;
            end else begin
                re_b0    = 1'b1;
                raddr_b0 = rd_addr;
            end
        end
    end

    // Next-state: start edge launches an unload; the n = 63 handshake ends it,
    // unless a start edge lands on that same cycle, which restarts at n = 0.
    always_comb begin
        state_d   = state_q;
        rd_n_d    = rd_n_q + {{LOGN{1'b0}}, rd_issue};
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_DRAIN;
                    rd_n_d  = '0;
                end
            end
            ST_DRAIN: begin
                if (start_edge && final_hs) begin
                    rd_n_d = '0;
                end else begin
                    if (start_edge) begin
                        overrun_d = 1'b1;
                    end
                    if (final_hs) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, edge detect, and the one-stage tag pipeline matching bank latency.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            armed_q      <= 1'b0;
            rd_n_q       <= '0;
            overrun_q    <= 1'b0;
            inflight_q   <= 1'b0;
            bank_q       <= 1'b0;
            n_q          <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= output_start;
            armed_q      <= armed_q | ~output_start;
            rd_n_q       <= rd_n_d;
            overrun_q    <= overrun_d;
            inflight_q   <= rd_issue;
            bank_q       <= rd_bank;
            n_q          <= rd_n_q[LOGN-1:0];
        end
    end

    assign fifo_wdata = {(bank_q ? rdata_b1 : rdata_b0), n_q, (n_q == LOGN'(N - 1))};

    fft_skid_fifo #(
        .W (EW)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push_i  (inflight_q),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_fft_output_unloader.sv
// Bench for fft_output_unloader: bank model preloaded with location k = k,
// scoreboard of expected bins, read-port and backpressure checks per cycle.
module tb_fft_output_unloader;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          nrst;
    logic          output_start;
    logic          re_b0, re_b1;
    logic [4:0]    raddr_b0, raddr_b1;
    logic [DW-1:0] rdata_b0, rdata_b1;
    logic          out_valid, out_ready, out_last, busy, overrun;
    logic [DW-1:0] out_data;
    logic [5:0]    out_index;

    logic [DW-1:0] mem0 [32];
    logic [DW-1:0] mem1 [32];

    typedef struct packed {
        logic [5:0]    idx;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rd_bank_log [64];
    int   rd_addr_log [64];

    fft_output_unloader #(.DW(DW)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .output_start (output_start),
        .re_b0        (re_b0),
        .re_b1        (re_b1),
        .raddr_b0     (raddr_b0),
        .raddr_b1     (raddr_b1),
        .rdata_b0     (rdata_b0),
        .rdata_b1     (rdata_b1),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Bank model: synchronous read, data one cycle after the enable.
    always @(posedge clk) begin
        if (re_b0) rdata_b0 <= mem0[raddr_b0];
        if (re_b1) rdata_b1 <= mem1[raddr_b1];
    end

    function automatic logic [5:0] m_bitrev(input logic [5:0] v);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[5-i] = v[i];
        return r;
    endfunction

    function automatic logic m_parity(input logic [5:0] v);
        int ones = 0;
        for (int i = 0; i < 6; i++) ones += int'(v[i]);
        return (ones % 2) == 1;
    endfunction

    task automatic push_stream();
        exp_t e;
        for (int n = 0; n < 64; n++) begin
            e.idx  = 6'(n);
            e.data = DW'(m_bitrev(6'(n)));
            e.last = (n == 63);
            exp_q.push_back(e);
        end
    endtask

    // Runs one unload after a start edge armed at the preceding negedge.
    // Cycle 1 is the first cycle after the start edge was sampled.
    task automatic drain(input bit rnd, input int ovr_cyc, input bit restart_last,
                         input int abort_bin, output int first_cyc, output int last_cyc);
        int            cyc = 0;
        int            rd_cnt = 0;
        int            acc = 0;
        bit            stalled = 1'b0;
        bit            hs;
        logic [DW-1:0] held_d = '0;
        logic [5:0]    held_i = '0;
        logic [5:0]    k;
        logic [5:0]    rn;
        logic          b;
        logic [4:0]    a;
        exp_t          e;
        first_cyc = -1;
        last_cyc  = -1;
        while (acc < 64) begin
            @(negedge clk);
            cyc++;
            if (cyc > 3000) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain_timeout: accepted %0d words, required 64", acc);
                return;
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc == 2) output_start = 1'b0;
            if (ovr_cyc > 0 && cyc == ovr_cyc) output_start = 1'b1;
            if (ovr_cyc > 0 && cyc == ovr_cyc + 2) output_start = 1'b0;
            if (abort_bin >= 0 && out_valid && out_index == 6'(abort_bin)) begin
                nrst = 1'b0;
                return;
            end
            if (restart_last && out_valid && out_last) begin
                out_ready    = 1'b1;
                output_start = 1'b1;
                push_stream();
            end
            #1;
            if (re_b0 || re_b1) begin
                rn = rd_cnt[5:0];
                k  = m_bitrev(rn);
                b  = m_parity(rn);
                a  = re_b1 ? raddr_b1 : raddr_b0;
                if (rd_cnt < 64) begin
                    rd_bank_log[rd_cnt] = int'(re_b1);
                    rd_addr_log[rd_cnt] = int'(a);
                end
                n_checks++;
                if (rd_cnt > 63 || (re_b0 && re_b1) || re_b1 !== b || a !== k[5:1]) begin
                    n_fail++;
                    $display("FAIL read_port: read %0d re_b0=%0b re_b1=%0b addr=%0d, required bank %0d addr %0d",
                             rd_cnt, re_b0, re_b1, a, b, k[5:1]);
                end
                rd_cnt++;
            end else begin
                n_checks++;
                if (raddr_b0 !== 5'd0 || raddr_b1 !== 5'd0) begin
                    n_fail++;
                    $display("FAIL idle_addr: raddr_b0=%0d raddr_b1=%0d, required 0 0", raddr_b0, raddr_b1);
                end
            end
            hs = out_valid && out_ready;
            n_checks++;
            if (rd_cnt - acc - int'(hs) > 2) begin
                n_fail++;
                $display("FAIL outstanding: %0d words beyond consumer, required <= 2", rd_cnt - acc - int'(hs));
            end
            if (stalled) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_index !== held_i) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%0b data=%0h idx=%0d, required 1 %0h %0d",
                             out_valid, out_data, out_index, held_d, held_i);
                end
            end
            stalled = out_valid && !out_ready;
            held_d  = out_data;
            held_i  = out_index;
            if (hs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: idx=%0d data=%0h, required no word", out_index, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_index !== e.idx || out_data !== e.data || out_last !== e.last) begin
                        n_fail++;
                        $display("FAIL stream_word: idx=%0d data=%0h last=%0b, required %0d %0h %0b",
                                 out_index, out_data, out_last, e.idx, e.data, e.last);
                    end
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                acc++;
            end
        end
    endtask

    task automatic test_reset();
        nrst         = 1'b0;
        output_start = 1'b0;
        out_ready    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({busy, overrun, out_valid, out_last, re_b0, re_b1} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/ovr/valid/last/re0/re1=%b, required 000000",
                     {busy, overrun, out_valid, out_last, re_b0, re_b1});
        end
        n_checks++;
        if (out_data !== '0 || out_index !== 6'd0 || raddr_b0 !== 5'd0 || raddr_b1 !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_data: data=%0h idx=%0d a0=%0d a1=%0d, required all 0",
                     out_data, out_index, raddr_b0, raddr_b1);
        end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        int f, l;
        output_start = 1'b1;
        push_stream();
        drain(1'b0, 0, 1'b0, -1, f, l);
        n_checks++;
        if (f != 3 || l != 66) begin
            n_fail++;
            $display("FAIL stream_timing: first=%0d last=%0d, required 3 66", f, l);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: busy=%0b valid=%0b, required 0 0", busy, out_valid);
        end
        n_checks++;
        if (rd_bank_log[1] != 1 || rd_addr_log[1] != 16 || rd_bank_log[3] != 0 || rd_addr_log[3] != 24 ||
            rd_bank_log[7] != 1 || rd_addr_log[7] != 28) begin
            n_fail++;
            $display("FAIL read_map: n1=%0d/%0d n3=%0d/%0d n7=%0d/%0d, required 1/16 0/24 1/28",
                     rd_bank_log[1], rd_addr_log[1], rd_bank_log[3], rd_addr_log[3],
                     rd_bank_log[7], rd_addr_log[7]);
        end
    endtask

    task automatic test_backpressure();
        int f, l;
        output_start = 1'b1;
        push_stream();
        drain(1'b1, 0, 1'b0, -1, f, l);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_end: busy=%0b left=%0d, required 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_restart_on_last();
        int f, l;
        output_start = 1'b1;
        push_stream();
        drain(1'b0, 0, 1'b1, -1, f, l);
        drain(1'b0, 0, 1'b0, -1, f, l);
        n_checks++;
        if (f != 3 || l != 66 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL restart: first=%0d last=%0d overrun=%0b, required 3 66 0", f, l, overrun);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_end: busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_overrun();
        int f, l;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_pre: overrun=%0b, required 0", overrun);
        end
        output_start = 1'b1;
        push_stream();
        drain(1'b0, 19, 1'b0, -1, f, l);
        n_checks++;
        if (overrun !== 1'b1 || f != 3 || l != 66 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL overrun: overrun=%0b first=%0d last=%0d left=%0d, required 1 3 66 0",
                     overrun, f, l, exp_q.size());
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_end: busy=%0b overrun=%0b, required 0 1", busy, overrun);
        end
    endtask

    task automatic test_reset_mid();
        int f, l;
        output_start = 1'b1;
        push_stream();
        drain(1'b0, 0, 1'b0, 30, f, l);
        @(negedge clk);
        #1;
        n_checks++;
        if ({busy, overrun, out_valid, out_last, re_b0, re_b1} !== 6'b0 || out_data !== '0 ||
            out_index !== 6'd0 || raddr_b0 !== 5'd0 || raddr_b1 !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%0b ovr=%0b valid=%0b data=%0h idx=%0d, required all 0",
                     busy, overrun, out_valid, out_data, out_index);
        end
        nrst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        output_start = 1'b1;
        push_stream();
        drain(1'b0, 0, 1'b0, -1, f, l);
        n_checks++;
        if (f != 3 || l != 66 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL after_reset: first=%0d last=%0d left=%0d, required 3 66 0", f, l, exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_start_held();
        int f, l;
        int bad = 0;
        nrst         = 1'b0;
        output_start = 1'b1;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (busy !== 1'b0 || re_b0 !== 1'b0 || re_b1 !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL held_start: %0d cycles active, required 0", bad);
        end
        output_start = 1'b0;
        @(negedge clk);
        output_start = 1'b1;
        push_stream();
        drain(1'b0, 0, 1'b0, -1, f, l);
        n_checks++;
        if (f != 3 || l != 66 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL held_then_edge: first=%0d last=%0d left=%0d, required 3 66 0", f, l, exp_q.size());
        end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) begin
            if (m_parity(6'(k))) mem1[k >> 1] = DW'(k);
            else                 mem0[k >> 1] = DW'(k);
        end
        rdata_b0 = '0;
        rdata_b1 = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_restart_on_last();
        test_overrun();
        test_reset_mid();
        test_start_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
